// File: rtl/axi_isolate_ctrl.sv
// AXI4 isolation controller: stops admitting new AW/AR on request, drains every
// outstanding write and read, then reports the master port quiescent.
package axi_isolate_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } resp_t;

endpackage

module axi_isolate_ctrl #(
  parameter int unsigned MaxTxns = 8,
  parameter type         req_t   = axi_isolate_pkg::req_t,
  parameter type         resp_t  = axi_isolate_pkg::resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  isolate_i,
  output logic  isolated_o,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i
);

  localparam int unsigned     CntW   = $clog2(MaxTxns + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    Normal,
    Drain,
    Isolated
  } state_e;

  state_e          state_q, state_d;
  logic            isolated_q;
  logic [CntW-1:0] wrCnt_q, wrCnt_d;
  logic [CntW-1:0] rdCnt_q, rdCnt_d;
  logic [CntW-1:0] wPend_q, wPend_d;
  logic            awOk, arOk, wOk;
  logic            awHs, wLastHs, bHs, arHs, rLastHs;

  // Simultaneous inc/dec cancel; a decrement at zero is a protocol error and holds.
  function automatic logic [CntW-1:0] stepCnt(input logic [CntW-1:0] cnt,
                                              input logic inc, input logic dec);
    logic [CntW-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CntOne;
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CntOne;
    end
    return res;
  endfunction

  always_comb begin
    awHs    = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    wLastHs = mst_req_o.w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
    bHs     = mst_resp_i.b_valid & slv_req_i.b_ready;
    arHs    = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    rLastHs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    wrCnt_d = stepCnt(wrCnt_q, awHs, bHs);
    rdCnt_d = stepCnt(rdCnt_q, arHs, rLastHs);
    wPend_d = stepCnt(wPend_q, awHs, wLastHs);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Normal;
      isolated_q <= 1'b0;
      wrCnt_q    <= '0;
      rdCnt_q    <= '0;
      wPend_q    <= '0;
    end else begin
      state_q    <= state_d;
      isolated_q <= (state_d == Isolated);
      wrCnt_q    <= wrCnt_d;
      rdCnt_q    <= rdCnt_d;
      wPend_q    <= wPend_d;
    end
  end

  // Drain completion looks at the post-update counts so ISOLATED follows the
  // final completion handshake by exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Normal:   if (isolate_i) state_d = Drain;
      Drain: begin
        if (!isolate_i) begin
          state_d = Normal;
        end else if ((wrCnt_d == '0) && (rdCnt_d == '0) && (wPend_d == '0)) begin
          state_d = Isolated;
        end
      end
      Isolated: if (!isolate_i) state_d = Normal;
      default:  state_d = Normal;
    endcase
  end

  always_comb begin
    awOk = (state_q == Normal) && (wrCnt_q < CntMax) && (wPend_q < CntMax);
    arOk = (state_q == Normal) && (rdCnt_q < CntMax);
    wOk  = (wPend_q != '0);

    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & awOk;
    mst_req_o.w_valid  = slv_req_i.w_valid & wOk;
    mst_req_o.ar_valid = slv_req_i.ar_valid & arOk;

    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & awOk;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & wOk;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & arOk;
  end

  assign isolated_o = isolated_q;

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(bHs && (wrCnt_q == '0)));
      assert (!(rLastHs && (rdCnt_q == '0)));
      assert (!(wLastHs && (wPend_q == '0)));
    end
  end

endmodule

// File: tb/tb_axi_isolate_ctrl.sv
// Randomized scoreboard bench for axi_isolate_ctrl against a queue-based model of
// outstanding bursts and the isolate/drain rules.
module tb_axi_isolate_ctrl;
  import axi_isolate_pkg::*;

  localparam int MaxTxns = 3;

  typedef struct {
    logic     mstAwValid;
    logic     slvAwReady;
    logic     mstWValid;
    logic     slvWReady;
    logic     mstArValid;
    logic     slvArReady;
    logic     slvBValid;
    logic     mstBReady;
    logic     slvRValid;
    logic     mstRReady;
    logic     isolated;
    ax_chan_t aw;
    ax_chan_t ar;
    w_chan_t  w;
    b_chan_t  b;
    r_chan_t  r;
  } expect_t;

  logic  clock = 1'b0;
  logic  resetN;
  logic  isolate;
  logic  isolated;
  req_t  slvReq, mstReq;
  resp_t slvResp, mstResp;

  int total = 0;
  int bad   = 0;

  expect_t expQ[$];

  // Model: remaining W beats per accepted AW, owed B responses, remaining R beats
  // per accepted AR, whether new transactions are admitted, and the isolated flag.
  int wQ[$];
  int rQ[$];
  int bCredits;
  bit admitting;
  bit isoModel;
  bit awBusy, wBusy, arBusy;

  axi_isolate_ctrl #(
    .MaxTxns(MaxTxns),
    .req_t  (req_t),
    .resp_t (resp_t)
  ) dut (
    .clk_i     (clock),
    .rst_ni    (resetN),
    .isolate_i (isolate),
    .isolated_o(isolated),
    .slv_req_i (slvReq),
    .slv_resp_o(slvResp),
    .mst_req_o (mstReq),
    .mst_resp_i(mstResp)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ax_chan_t randAx();
    ax_chan_t a;
    a.id   = 4'($urandom);
    a.addr = $urandom;
    a.len  = 8'($urandom_range(3));
    return a;
  endfunction

  task automatic clearModel();
    wQ.delete();
    rQ.delete();
    bCredits  = 0;
    admitting = 1'b1;
    isoModel  = 1'b0;
    awBusy    = 1'b0;
    wBusy     = 1'b0;
    arBusy    = 1'b0;
  endtask

  task automatic driveIdle();
    slvReq  = '0;
    mstResp = '0;
    isolate = 1'b0;
  endtask

  // Drive one cycle of random traffic, queue the expected outputs, advance the model.
  task automatic applyStimulus(input logic iso, input int unsigned pAw, input int unsigned pAr,
                               input int unsigned pW, input int unsigned pReady,
                               input int unsigned pResp);
    expect_t e;
    logic awOk, arOk, wOk, awHs, arHs, wHs, bHs, rHs;
    isolate = iso;

    if (!awBusy) begin
      slvReq.aw_valid = ($urandom_range(99) < pAw);
      slvReq.aw       = randAx();
    end
    if (!arBusy) begin
      slvReq.ar_valid = ($urandom_range(99) < pAr);
      slvReq.ar       = randAx();
    end
    slvReq.w_valid = wBusy ? 1'b1 : ($urandom_range(99) < pW);
    slvReq.w.data  = $urandom;
    slvReq.w.strb  = 4'($urandom);
    slvReq.w.last  = (wQ.size() > 0) ? (wQ[0] == 1) : 1'($urandom_range(1));
    slvReq.b_ready = ($urandom_range(99) < pReady);
    slvReq.r_ready = ($urandom_range(99) < pReady);

    mstResp.aw_ready = ($urandom_range(99) < pReady);
    mstResp.w_ready  = ($urandom_range(99) < pReady);
    mstResp.ar_ready = ($urandom_range(99) < pReady);
    mstResp.b_valid  = (bCredits > 0) && ($urandom_range(99) < pResp);
    mstResp.b.id     = 4'($urandom);
    mstResp.b.resp   = 2'($urandom);
    mstResp.r_valid  = (rQ.size() > 0) && ($urandom_range(99) < pResp);
    mstResp.r.id     = 4'($urandom);
    mstResp.r.data   = $urandom;
    mstResp.r.resp   = 2'($urandom);
    mstResp.r.last   = (rQ.size() > 0) ? (rQ[0] == 1) : 1'b0;

    awOk = admitting && ((wQ.size() + bCredits) < MaxTxns) && (wQ.size() < MaxTxns);
    arOk = admitting && (rQ.size() < MaxTxns);
    wOk  = (wQ.size() > 0);

    e.mstAwValid = slvReq.aw_valid & awOk;
    e.slvAwReady = mstResp.aw_ready & awOk;
    e.mstWValid  = slvReq.w_valid & wOk;
    e.slvWReady  = mstResp.w_ready & wOk;
    e.mstArValid = slvReq.ar_valid & arOk;
    e.slvArReady = mstResp.ar_ready & arOk;
    e.slvBValid  = mstResp.b_valid;
    e.mstBReady  = slvReq.b_ready;
    e.slvRValid  = mstResp.r_valid;
    e.mstRReady  = slvReq.r_ready;
    e.isolated   = isoModel;
    e.aw         = slvReq.aw;
    e.ar         = slvReq.ar;
    e.w          = slvReq.w;
    e.b          = mstResp.b;
    e.r          = mstResp.r;
    expQ.push_back(e);

    awHs = slvReq.aw_valid & awOk & mstResp.aw_ready;
    arHs = slvReq.ar_valid & arOk & mstResp.ar_ready;
    wHs  = slvReq.w_valid & wOk & mstResp.w_ready;
    bHs  = mstResp.b_valid & slvReq.b_ready;
    rHs  = mstResp.r_valid & slvReq.r_ready;

    if (bHs) bCredits--;
    if (wHs) begin
      wQ[0] = wQ[0] - 1;
      if (wQ[0] == 0) begin
        void'(wQ.pop_front());
        bCredits++;
      end
    end
    if (awHs) wQ.push_back(int'(slvReq.aw.len) + 1);
    if (rHs) begin
      rQ[0] = rQ[0] - 1;
      if (rQ[0] == 0) void'(rQ.pop_front());
    end
    if (arHs) rQ.push_back(int'(slvReq.ar.len) + 1);

    isoModel  = iso && !admitting && (wQ.size() == 0) && (bCredits == 0) && (rQ.size() == 0);
    admitting = !iso;
    awBusy    = slvReq.aw_valid && !awHs;
    arBusy    = slvReq.ar_valid && !arHs;
    wBusy     = slvReq.w_valid && !wHs;
  endtask

  task automatic runCycles(input int n, input logic iso, input int unsigned pAw,
                           input int unsigned pAr, input int unsigned pW,
                           input int unsigned pReady, input int unsigned pResp);
    repeat (n) begin
      @(negedge clock);
      applyStimulus(iso, pAw, pAr, pW, pReady, pResp);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    resetN = 1'b0;
    clearModel();
    driveIdle();
    slvReq.aw_valid = 1'b1;
    slvReq.w_valid  = 1'b1;
    slvReq.ar_valid = 1'b1;
    #1;
    checkOutput("reset_isolated", 64'(isolated), 64'd0);
    checkOutput("reset_aw_pass", 64'(mstReq.aw_valid), 64'd1);
    checkOutput("reset_ar_pass", 64'(mstReq.ar_valid), 64'd1);
    checkOutput("reset_w_blocked", 64'(mstReq.w_valid), 64'd0);
    @(negedge clock);
    driveIdle();
    @(negedge clock);
    resetN = 1'b1;
  endtask

  // Monitor: compares every cycle's DUT outputs against the queued expectation.
  initial begin
    expect_t e;
    forever begin
      @(negedge clock);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("mst_aw_valid", 64'(mstReq.aw_valid), 64'(e.mstAwValid));
        checkOutput("slv_aw_ready", 64'(slvResp.aw_ready), 64'(e.slvAwReady));
        checkOutput("mst_w_valid", 64'(mstReq.w_valid), 64'(e.mstWValid));
        checkOutput("slv_w_ready", 64'(slvResp.w_ready), 64'(e.slvWReady));
        checkOutput("mst_ar_valid", 64'(mstReq.ar_valid), 64'(e.mstArValid));
        checkOutput("slv_ar_ready", 64'(slvResp.ar_ready), 64'(e.slvArReady));
        checkOutput("slv_b_valid", 64'(slvResp.b_valid), 64'(e.slvBValid));
        checkOutput("mst_b_ready", 64'(mstReq.b_ready), 64'(e.mstBReady));
        checkOutput("slv_r_valid", 64'(slvResp.r_valid), 64'(e.slvRValid));
        checkOutput("mst_r_ready", 64'(mstReq.r_ready), 64'(e.mstRReady));
        checkOutput("isolated", 64'(isolated), 64'(e.isolated));
        checkOutput("aw_payload", 64'(mstReq.aw), 64'(e.aw));
        checkOutput("ar_payload", 64'(mstReq.ar), 64'(e.ar));
        checkOutput("w_payload", 64'(mstReq.w), 64'(e.w));
        checkOutput("b_payload", 64'(slvResp.b), 64'(e.b));
        checkOutput("r_payload", 64'(slvResp.r), 64'(e.r));
      end
    end
  end

  initial begin
    resetN = 1'b1;
    clearModel();
    driveIdle();
    doReset();

    $display("[TB] normal traffic");
    runCycles(400, 1'b0, 60, 60, 70, 70, 60);

    $display("[TB] isolate windows");
    repeat (30) begin
      runCycles($urandom_range(30, 3), 1'b1, 60, 60, 80, 80, 70);
      runCycles($urandom_range(15, 1), 1'b0, 60, 60, 80, 80, 70);
    end

    $display("[TB] saturation");
    runCycles(200, 1'b0, 90, 90, 80, 90, 5);

    $display("[TB] isolate pulses");
    repeat (40) begin
      runCycles(1, 1'b1, 70, 70, 70, 70, 40);
      runCycles(3, 1'b0, 70, 70, 70, 70, 40);
    end

    $display("[TB] idle isolation");
    runCycles(60, 1'b0, 0, 0, 100, 100, 100);
    runCycles(10, 1'b1, 0, 0, 100, 100, 100);
    runCycles(5, 1'b0, 0, 0, 100, 100, 100);

    $display("[TB] reset mid-traffic");
    runCycles(20, 1'b0, 90, 90, 50, 50, 20);
    doReset();
    runCycles(300, 1'b0, 60, 60, 70, 70, 60);
    repeat (10) begin
      runCycles($urandom_range(25, 2), 1'b1, 50, 50, 80, 80, 80);
      runCycles($urandom_range(10, 1), 1'b0, 50, 50, 80, 80, 80);
    end

    @(negedge clock);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
